// File: rtl/rsc_pkg.sv
// Shared types for the RSC constituent encoder: FSM encoding, output pair layout,
// LTE default polynomials and the masked XOR-reduce used for feedback and parity.
package rsc_pkg;

   typedef enum logic {
      ENC  = 1'b0,
      TAIL = 1'b1
   } rsc_state_e;

   typedef struct packed {
      logic x;
      logic z;
      logic tail;
      logic last;
   } rsc_pair_t;

   localparam logic [3:0] RSC_G_FB_LTE = 4'b1101;
   localparam logic [3:0] RSC_G_FF_LTE = 4'b1011;

   // Wide enough for the largest legal memory (M = 6).
   localparam int RSC_VEC_W = 8;

   function automatic logic rsc_parity(input logic [RSC_VEC_W-1:0] vec,
                                       input logic [RSC_VEC_W-1:0] poly);
      return ^(vec & poly);
   endfunction

endpackage

// File: rtl/rsc_out_stage.sv
// One-deep valid/ready slice for {x, z, tail, last}, latency 1, full throughput.
// Holds its pair while pop_rdy is low; free says a push can land this cycle.
module rsc_out_stage
   import rsc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_N,
   input  logic       push_vld,
   input  logic [3:0] push_dat,
   output logic       free,
   output logic       pop_vld,
   output logic [3:0] pop_dat,
   input  logic       pop_rdy
);

   logic      vld_q, vld_d;
   rsc_pair_t dat_q, dat_d;

   assign free    = !vld_q || pop_rdy;
   assign pop_vld = vld_q;
   assign pop_dat = dat_q;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (push_vld && free) begin
         vld_d = 1'b1;
         dat_d = rsc_pair_t'(push_dat);
      end else if (pop_rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

endmodule

// File: rtl/rsc_param.sv
// Parametrised RSC encoder with block framing and K_MAX guard, latency 1, stalls on out_ready.
// RSC_PARAM_TERM_EN adds M trellis-termination pairs per block; otherwise the final state is dropped.
module rsc_param
   import rsc_pkg::*;
#(
   parameter int         M     = 3,
   parameter logic [M:0] G_FB  = (M+1)'(RSC_G_FB_LTE),
   parameter logic [M:0] G_FF  = (M+1)'(RSC_G_FF_LTE),
   parameter int         K_MAX = 6144
) (
   input  logic clk,
   input  logic rst_N,
   input  logic in_valid,
   input  logic in_bit,
   input  logic in_last,
   output logic in_ready,
   output logic out_valid,
   output logic out_x,
   output logic out_z,
   output logic out_tail,
   output logic out_last,
   input  logic out_ready,
   output logic blk_err
);

   localparam int CW = $clog2(K_MAX + 1);
`ifdef RSC_PARAM_TERM_EN
   localparam logic TERM = 1'b1;
`else
   localparam logic TERM = 1'b0;
`endif

   if (M < 2 || M > 6 || G_FB[0] != 1'b1) begin : g_bad_cfg
      $error("rsc_param: M must be 2..6 and G_FB[0] must be 1");
   end

   rsc_state_e    state_q, state_d;
   logic [M-1:0]  r_q, r_d;          // r_q[0] holds r[1], the newest bit
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    tcnt_q, tcnt_d;
   logic          run_q;
   logic          blk_err_q, blk_err_d;

   logic      f, ffr, a;
   logic      at_limit, close_blk;
   logic      stage_free, push_vld;
   rsc_pair_t pair, pop;
   logic [3:0] pop_dat;

   assign f         = rsc_parity(RSC_VEC_W'(r_q), RSC_VEC_W'(G_FB[M:1]));
   assign ffr       = rsc_parity(RSC_VEC_W'(r_q), RSC_VEC_W'(G_FF[M:1]));
   assign at_limit  = (cnt_q == CW'(K_MAX - 1));
   assign close_blk = in_last || at_limit;
   assign in_ready  = run_q && (state_q == ENC) && stage_free;

   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      tcnt_d    = tcnt_q;
      blk_err_d = 1'b0;
      push_vld  = 1'b0;
      pair      = '0;
      a         = 1'b0;
      case (state_q)
         ENC: begin
            if (in_valid && in_ready) begin
               a        = in_bit ^ f;
               push_vld = 1'b1;
               pair.x   = in_bit;
               pair.z   = (G_FF[0] & a) ^ ffr;
               r_d      = {r_q[M-2:0], a};
               cnt_d    = cnt_q + CW'(1);
               if (close_blk) begin
                  cnt_d     = '0;
                  blk_err_d = !in_last;
                  if (TERM) begin
                     state_d = TAIL;
                  end else begin
                     pair.last = 1'b1;
                     r_d       = '0;
                  end
               end
            end
         end
         TAIL: begin
            // Feeding u = f forces a = 0, so M shifts drain the trellis to state 0.
            if (stage_free) begin
               push_vld  = 1'b1;
               pair.x    = f;
               pair.z    = ffr;
               pair.tail = 1'b1;
               r_d       = {r_q[M-2:0], 1'b0};
               tcnt_d    = tcnt_q + 3'd1;
               if (tcnt_q == 3'(M - 1)) begin
                  pair.last = 1'b1;
                  tcnt_d    = '0;
                  r_d       = '0;
                  state_d   = ENC;
               end
            end
         end
         default: state_d = ENC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         state_q   <= ENC;
         r_q       <= '0;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         run_q     <= 1'b0;
         blk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         run_q     <= 1'b1;
         blk_err_q <= blk_err_d;
      end
   end

   rsc_out_stage u_out_stage (
      .clk      (clk),
      .rst_N    (rst_N),
      .push_vld (push_vld),
      .push_dat (pair),
      .free     (stage_free),
      .pop_vld  (out_valid),
      .pop_dat  (pop_dat),
      .pop_rdy  (out_ready)
   );

   assign pop      = rsc_pair_t'(pop_dat);
   assign out_x    = pop.x;
   assign out_z    = pop.z;
   assign out_tail = TERM ? pop.tail : 1'b0;
   assign out_last = pop.last;
   assign blk_err  = blk_err_q;

endmodule

// File: doc/rsc_param.md
# rsc_param

Parametrised recursive systematic convolutional (RSC) encoder, the next generation of the turbo-encoder constituent coder. It has configurable memory depth, feedback and feedforward polynomials, valid/ready streaming on both sides, block framing, a maximum block length guard, and optional trellis termination. Two instances sit in the turbo encoder top, one fed directly and one fed through the interleaver.

## Interface
- `M`, default 3: encoder memory (trellis has 2^M states); legal 2..6.
- `G_FB`, default 4'b1101: feedback polynomial, [M:0], bit i = coefficient of D^i; bit 0 must be 1.
- `G_FF`, default 4'b1011: feedforward (parity) polynomial, [M:0], same bit convention.
- `K_MAX`, default 6144: maximum information bits per block.
- `clk` in 1: single clock, rising edge.
- `rst_N` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: information bit present.
- `in_bit` in 1: information bit u.
- `in_last` in 1: u is the final bit of the block.
- `in_ready` out 1: encoder accepts u this cycle.
- `out_valid` out 1: output pair present.
- `out_x` out 1: systematic bit (info or tail).
- `out_z` out 1: parity bit.
- `out_tail` out 1: the current pair is a termination pair.
- `out_last` out 1: final pair of the block.
- `out_ready` in 1: downstream accepts the pair.
- `blk_err` out 1: one-cycle pulse, block forced closed at `K_MAX`.

## Operation
- State register r[1..M]; r[1] is the newest bit.
- Feedback f = XOR over i=1..M of (G_FB[i] & r[i]).
- Encode step with input u:
  - a = u ^ f.
  - x = u.
  - z = (G_FF[0] & a) ^ XOR over i=1..M of (G_FF[i] & r[i]).
  - Shift: r[1] <= a, r[i] <= r[i-1].
- Tail step: u = f, so a = 0. Outputs x = f and z computed with a = 0. After M tail steps, r = 0.
- FSM:
  - ENC to ENC on an accepted non-last bit.
  - ENC to TAIL on an accepted last bit (explicit `in_last` or forced).
  - TAIL to ENC when tail counter = M-1 and that pair is accepted.
- In ENC, r is cleared on the step following the last pair, so each block starts from state 0.
- Block counter (clog2(K_MAX+1) bits):
  - Increments per accepted info bit; cleared when the block closes.
  - If the bit accepted at count K_MAX-1 does not carry `in_last`, it is treated as last, and `blk_err` pulses in the same cycle that pair is registered.
- `in_ready` = (state == ENC) && (!out_valid || out_ready). It is deasserted throughout TAIL.
- `out_tail` = 1 for the M tail pairs. `out_last` = 1 on tail pair M.

## Timing
- Outputs are registered. A pair appears on the `out_*` lines the cycle after the `in_valid && in_ready` transfer: latency 1.
- One-deep output stage:
  - `out_*` hold stable while `out_valid && !out_ready`.
  - Full throughput of 1 pair/cycle when `out_ready` = 1.
- Tail pairs are issued on consecutive cycles, each gated by `out_ready`. The tail counter advances only on acceptance.
- Simultaneous events:
  - Output acceptance and a new input transfer in the same cycle both take effect.
  - `in_last` with count = K_MAX-1 closes the block normally; `blk_err` stays 0.
- Reset values: `out_valid` 0, `out_x` 0, `out_z` 0, `out_tail` 0, `out_last` 0, `blk_err` 0, `in_ready` 0 during reset. r = 0, FSM = ENC, counters = 0.
- `rst_N` asserted mid-block or mid-tail aborts immediately. No partial tail is emitted after release.
- `in_ready` rises the first cycle after `rst_N` deasserts.

## Configuration
- `RSC_PARAM_TERM_EN` defined: trellis termination as described (M tail pairs per block).
- Undefined:
  - No TAIL state.
  - `out_tail` is tied 0.
  - `out_last` marks the final info pair.
  - r is cleared when that pair is accepted. The encoder is non-terminated, and the final state is discarded.

## Structure
- `rsc_pkg`:
  - FSM state enum (ENC, TAIL).
  - Default LTE polynomials `RSC_G_FB_LTE` = 4'b1101 and `RSC_G_FF_LTE` = 4'b1011.
  - A function `rsc_parity(vec, poly)` for masked XOR-reduce.
- One sub-module, `rsc_out_stage`: 1-deep valid/ready register slice holding {x, z, tail, last}.
- Polynomial legality (G_FB[0] = 1, 2 ≤ M ≤ 6) is checked in an elaboration-time assertion.

## Test plan
- Defaults, K=1, u=1, `out_ready` held 1 -> pairs (x,z) = (1,1),(0,1),(1,0),(1,1). `out_tail` is 0,1,1,1 and `out_last` is on pair 4.
- Defaults, K=40, all-zero input -> 43 pairs, all (0,0); internal r = 0 after `out_last`.
- Random 1000-bit block with `out_ready` toggling randomly -> pairs match a bit-exact golden model, no pair lost or duplicated, and `in_ready` = 0 throughout tail.
- K_MAX=8, 10 bits streamed without `in_last` -> block closes after bit 8 with `blk_err` pulsing once. Bits 9-10 start a new block from state 0.
- `rst_N` pulsed low during tail pair 2 -> all outputs 0 next cycle, and the next block encodes as if from power-up.
- `RSC_PARAM_TERM_EN` undefined, K=1, u=1 -> a single pair (1,1) with `out_last` = 1 and `out_tail` = 0.
